// File: rtl/miriscv_lsu.sv
// Load/store unit: turns one core memory instruction into a single request/grant/rvalid
// transaction, with lane steering for stores and sign/zero extension for loads.
module miriscv_lsu (
    input  logic        clk_i,
    input  logic        arstn_i,

    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_err_o,

    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic        data_req_q, data_req_d;
    logic        data_we_q, data_we_d;
    logic [3:0]  data_be_q, data_be_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [31:0] data_wdata_q, data_wdata_d;
    logic [31:0] lsu_data_q, lsu_data_d;
    logic        lsu_err_q, lsu_err_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;

    logic        size_legal;
    logic        misaligned;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    // Picks the addressed byte/half out of the returned word and extends it.
    function automatic logic [31:0] extract(input logic [2:0]  size,
                                            input logic [1:0]  off,
                                            input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = rdata >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            LDST_B:  extract = {{24{b[7]}}, b};
            LDST_BU: extract = {24'h0, b};
            LDST_H:  extract = {{16{h[15]}}, h};
            LDST_HU: extract = {16'h0, h};
            default: extract = rdata;
        endcase
    endfunction

    always_comb begin
        size_legal = 1'b0;
        misaligned = 1'b0;
        be_c       = 4'b0000;
        wdata_c    = 32'h0;
        case (lsu_size_i)
            LDST_B, LDST_BU: begin
                size_legal = 1'b1;
                be_c       = 4'b0001 << lsu_addr_i[1:0];
                wdata_c    = {4{lsu_data_i[7:0]}};
            end
            LDST_H, LDST_HU: begin
                size_legal = 1'b1;
                misaligned = lsu_addr_i[0];
                be_c       = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{lsu_data_i[15:0]}};
            end
            LDST_W: begin
                size_legal = 1'b1;
                misaligned = (lsu_addr_i[1:0] != 2'b00);
                be_c       = 4'b1111;
                wdata_c    = lsu_data_i;
            end
            default: ;
        endcase
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        data_req_d   = data_req_q;
        data_we_d    = data_we_q;
        data_be_d    = data_be_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        lsu_data_d   = lsu_data_q;
        lsu_err_d    = 1'b0;
        size_d       = size_q;
        off_d        = off_q;
        case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    if (size_legal && !misaligned) begin
                        state_d      = REQ;
                        data_req_d   = 1'b1;
                        data_we_d    = lsu_we_i;
                        data_be_d    = be_c;
                        data_addr_d  = {lsu_addr_i[31:2], 2'b00};
                        data_wdata_d = wdata_c;
                        size_d       = lsu_size_i;
                        off_d        = lsu_addr_i[1:0];
                    end else begin
                        state_d   = DONE;
                        lsu_err_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    data_req_d = 1'b0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (data_rvalid_i) begin
                    state_d = DONE;
                    if (!data_we_q) lsu_data_d = extract(size_q, off_q, data_rdata_i);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q      <= IDLE;
            data_req_q   <= 1'b0;
            data_we_q    <= 1'b0;
            data_be_q    <= 4'b0000;
            data_addr_q  <= 32'h0;
            data_wdata_q <= 32'h0;
            lsu_data_q   <= 32'h0;
            lsu_err_q    <= 1'b0;
            size_q       <= 3'd0;
            off_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            data_req_q   <= data_req_d;
            data_we_q    <= data_we_d;
            data_be_q    <= data_be_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            lsu_data_q   <= lsu_data_d;
            lsu_err_q    <= lsu_err_d;
            size_q       <= size_d;
            off_q        <= off_d;
        end
    end

    assign lsu_stall_req_o = lsu_req_i && (state_q != DONE);
    assign lsu_data_o      = lsu_data_q;
    assign lsu_err_o       = lsu_err_q;
    assign data_req_o      = data_req_q;
    assign data_we_o       = data_we_q;
    assign data_be_o       = data_be_q;
    assign data_addr_o     = data_addr_q;
    assign data_wdata_o    = data_wdata_q;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed bench for miriscv_lsu: a small memory responder with programmable grant and
// rvalid latency, plus hand-computed lane, extension, stall and error expectations.
module tb_miriscv_lsu;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    int n_checks = 0;
    int n_errors = 0;

    miriscv_lsu dut (
        .clk_i           (clk_i),
        .arstn_i         (arstn_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_data_o      (lsu_data_o),
        .lsu_stall_req_o (lsu_stall_req_o),
        .lsu_err_o       (lsu_err_o),
        .data_req_o      (data_req_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_addr_o     (data_addr_o),
        .data_wdata_o    (data_wdata_o),
        .data_gnt_i      (data_gnt_i),
        .data_rvalid_i   (data_rvalid_i),
        .data_rdata_i    (data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts at one time unit after a rising edge with the LSU idle; ends the same way.
    task automatic run_access(
        input string       tag,
        input logic        we,
        input logic [2:0]  size,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [31:0] rdata,
        input int          gnt_dly,
        input int          rv_dly,
        input bit          noise,
        input bit          drop,
        input logic        exp_err,
        input logic [3:0]  exp_be,
        input logic [31:0] exp_wdata,
        input logic [31:0] exp_ldata,
        input int          exp_stall
    );
        int stall_cnt = 0;
        int req_cyc   = 0;
        int wait_cyc  = 0;
        bit granted   = 1'b0;
        bit rv_given  = 1'b0;
        bit saw_req   = 1'b0;
        bit stable_ok = 1'b1;
        bit finished  = 1'b0;
        bit req_seen;

        lsu_req_i    = 1'b1;
        lsu_we_i     = we;
        lsu_size_i   = size;
        lsu_addr_i   = addr;
        lsu_data_i   = wdata;
        data_rdata_i = rdata;
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (exp_err ? (cyc == 1) : rv_given) begin
                finished = 1'b1;
                break;
            end
            if (drop && cyc == 1) lsu_req_i = 1'b0;
            // Inputs that must be ignored are scrambled after issue.
            if (cyc == 1) begin
                lsu_size_i = 3'd2;
                lsu_addr_i = 32'hFFFF_FFFF;
                lsu_data_i = 32'h5555_5555;
                lsu_we_i   = ~we;
            end
            data_gnt_i    = (!granted && data_req_o) ? (req_cyc == gnt_dly) : noise;
            data_rvalid_i = granted ? (wait_cyc == rv_dly) : noise;
            #1;
            if (lsu_stall_req_o) stall_cnt++;
            req_seen = data_req_o;
            if (req_seen) begin
                saw_req = 1'b1;
                if (data_we_o !== we || data_be_o !== exp_be ||
                    data_addr_o !== {addr[31:2], 2'b00} || data_wdata_o !== exp_wdata)
                    stable_ok = 1'b0;
            end
            @(posedge clk_i);
            if (granted) begin
                if (data_rvalid_i) rv_given = 1'b1;
                else wait_cyc++;
            end else if (req_seen) begin
                if (data_gnt_i) granted = 1'b1;
                else req_cyc++;
            end
            #1;
        end
        check({tag, "_finished"}, 32'(finished), 32'd1);
        data_gnt_i    = 1'b0;
        data_rvalid_i = noise;
        #1;
        check({tag, "_stall_done"}, 32'(lsu_stall_req_o), 32'd0);
        check({tag, "_stall_cycles"}, stall_cnt, exp_stall);
        check({tag, "_ldata"}, lsu_data_o, exp_ldata);
        check({tag, "_err"}, 32'(lsu_err_o), 32'(exp_err));
        check({tag, "_issued"}, 32'(saw_req), 32'(!exp_err));
        check({tag, "_req_stable"}, 32'(stable_ok), 32'd1);
        lsu_req_i     = 1'b0;
        data_rvalid_i = 1'b0;
        @(posedge clk_i);
        #1;
        check({tag, "_err_clear"}, 32'(lsu_err_o), 32'd0);
        check({tag, "_req_clear"}, 32'(data_req_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arstn_i       = 1'b0;
        lsu_req_i     = 1'b0;
        lsu_we_i      = 1'b0;
        lsu_size_i    = 3'd0;
        lsu_addr_i    = 32'h0;
        lsu_data_i    = 32'h0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0;
        #1;
        check("rst_req",   32'(data_req_o), 32'd0);
        check("rst_be",    32'(data_be_o), 32'd0);
        check("rst_addr",  data_addr_o, 32'd0);
        check("rst_ldata", lsu_data_o, 32'd0);
        check("rst_err",   32'(lsu_err_o), 32'd0);
        check("rst_stall", 32'(lsu_stall_req_o), 32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        arstn_i = 1'b1;

        //          tag     we    size  addr          wdata         rdata         g  r  nz dr err be       exp_wdata     exp_ldata     stall
        run_access("lw",    1'b0, 3'd2, 32'h100, 32'h0,         32'hDEADBEEF, 0, 0, 0, 0, 1'b0, 4'b1111, 32'h0,         32'hDEADBEEF, 3);
        run_access("lb",    1'b0, 3'd0, 32'h103, 32'h0,         32'h80FFFF00, 0, 0, 0, 0, 1'b0, 4'b1000, 32'h0,         32'hFFFFFF80, 3);
        run_access("lbu",   1'b0, 3'd4, 32'h103, 32'h0,         32'h80FFFF00, 0, 0, 0, 0, 1'b0, 4'b1000, 32'h0,         32'h00000080, 3);
        run_access("sh",    1'b1, 3'd1, 32'h022, 32'h1234ABCD,  32'hFFFFFFFF, 0, 0, 0, 0, 1'b0, 4'b1100, 32'hABCDABCD,  32'h00000080, 3);
        run_access("lw_mis",1'b0, 3'd2, 32'h102, 32'h0,         32'h0,        0, 0, 0, 0, 1'b1, 4'b0000, 32'h0,         32'h00000080, 1);
        run_access("lh_mis",1'b0, 3'd1, 32'h101, 32'h0,         32'h0,        0, 0, 1, 0, 1'b1, 4'b0000, 32'h0,         32'h00000080, 1);
        run_access("ill_sz",1'b0, 3'd3, 32'h100, 32'h0,         32'h0,        0, 0, 0, 0, 1'b1, 4'b0000, 32'h0,         32'h00000080, 1);
        run_access("lh",    1'b0, 3'd1, 32'h102, 32'h0,         32'h80011234, 0, 0, 1, 0, 1'b0, 4'b1100, 32'h0,         32'hFFFF8001, 3);
        run_access("lhu",   1'b0, 3'd5, 32'h106, 32'h0,         32'h80011234, 0, 0, 0, 0, 1'b0, 4'b1100, 32'h0,         32'h00008001, 3);
        run_access("sb",    1'b1, 3'd0, 32'h101, 32'h1122335A,  32'hFFFFFFFF, 0, 0, 0, 0, 1'b0, 4'b0010, 32'h5A5A5A5A,  32'h00008001, 3);
        run_access("sw",    1'b1, 3'd2, 32'h10C, 32'hCAFEF00D,  32'hFFFFFFFF, 0, 0, 0, 0, 1'b0, 4'b1111, 32'hCAFEF00D,  32'h00008001, 3);
        run_access("lw_slow",1'b0,3'd2, 32'h200, 32'h0,         32'h01234567, 3, 2, 1, 0, 1'b0, 4'b1111, 32'h0,         32'h01234567, 8);
        run_access("lw_drop",1'b0,3'd2, 32'h204, 32'h0,         32'h0BADF00D, 1, 1, 0, 1, 1'b0, 4'b1111, 32'h0,         32'h0BADF00D, 1);

        // Reset while waiting for rvalid, then a stray rvalid after release.
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_size_i = 3'd2;
        lsu_addr_i = 32'h300;
        @(posedge clk_i);
        #1;
        data_gnt_i = 1'b1;
        @(posedge clk_i);
        #1;
        data_gnt_i = 1'b0;
        check("wait_req_low", 32'(data_req_o), 32'd0);
        #2;
        arstn_i = 1'b0;
        #1;
        check("mid_rst_we",    32'(data_we_o), 32'd0);
        check("mid_rst_be",    32'(data_be_o), 32'd0);
        check("mid_rst_addr",  data_addr_o, 32'd0);
        check("mid_rst_wdata", data_wdata_o, 32'd0);
        check("mid_rst_ldata", lsu_data_o, 32'd0);
        check("mid_rst_err",   32'(lsu_err_o), 32'd0);
        lsu_req_i = 1'b0;
        @(posedge clk_i);
        #1;
        arstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hFFFFFFFF;
        @(posedge clk_i);
        #1;
        data_rvalid_i = 1'b0;
        check("late_rv_ldata", lsu_data_o, 32'd0);
        check("late_rv_req",   32'(data_req_o), 32'd0);
        check("late_rv_stall", 32'(lsu_stall_req_o), 32'd0);
        run_access("post_rst_lbu", 1'b0, 3'd4, 32'h301, 32'h0, 32'h0000AB00, 0, 0, 0, 0,
                   1'b0, 4'b0010, 32'h0, 32'h000000AB, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
